// File: rtl/sram_read_sequencer.sv
// Purpose: round-robin sequencer issuing sub-word SRAM reads through the output shifter.
// Latency: request handshake to resp_valid is SRAM_LAT+2 cycles; one request in flight.
// Backpressure: requests wait while busy; resp held stable until resp_ready.
// Optional build macro OSEQ_ALIGN_CHECK_EN: flags misaligned/unsupported requests via resp_err.
module sram_read_sequencer #(
    parameter int WORD_AW  = 8,
    parameter int SRAM_LAT = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req0_valid,
    output logic                 req0_ready,
    input  logic [WORD_AW+4:0]   req0_addr,
    input  logic [2:0]           req0_conf,
    input  logic                 req1_valid,
    output logic                 req1_ready,
    input  logic [WORD_AW+4:0]   req1_addr,
    input  logic [2:0]           req1_conf,
    output logic                 sram_en,
    output logic [WORD_AW-1:0]   sram_addr,
    output logic [2:0]           shf_conf,
    output logic [4:0]           shf_addr,
    input  logic [31:0]          shf_dout,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic                 resp_id,
    output logic [31:0]          resp_data,
    output logic                 resp_err
);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, CAPTURE, RESP} state_t;

    localparam logic [2:0] CNT_INIT = 3'(SRAM_LAT - 1);

    state_t             state, state_nxt;
    logic               ptr;        // 1: requester 1 has priority on the next conflict
    logic [2:0]         cnt;
    logic               lat_id;
    logic               gnt0, gnt1;
    logic               hs;
    logic               sel_id;
    logic [WORD_AW+4:0] sel_addr;
    logic [2:0]         sel_conf;
    logic [2:0]         conf_eff;
    logic               sel_err;

    // Arbitration: a lone requester wins, on conflict the one not granted last wins.
    always_comb begin
        gnt0     = req0_valid && (!req1_valid || !ptr);
        gnt1     = req1_valid && (!req0_valid || ptr);
        hs       = (state == IDLE) && (gnt0 || gnt1);
        sel_id   = gnt1;
        sel_addr = sel_id ? req1_addr : req0_addr;
        sel_conf = sel_id ? req1_conf : req0_conf;
        // 110/111 are not real widths; run them as full 32-bit reads
        conf_eff = (sel_conf[2] && sel_conf[1]) ? 3'b000 : sel_conf;
`ifdef OSEQ_ALIGN_CHECK_EN
        // offset must be a multiple of the access width: low (5-conf) bits clear
        sel_err  = (sel_conf[2] && sel_conf[1]) ||
                   (|(sel_addr[4:0] & (5'h1f >> sel_conf)));
`else
        sel_err  = 1'b0;
`endif
    end

    // Next-state and per-state strobes.
    always_comb begin
        state_nxt  = state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        sram_en    = 1'b0;
        resp_valid = 1'b0;
        case (state)
            IDLE: begin
                req0_ready = gnt0;
                req1_ready = gnt1;
                if (hs) state_nxt = sel_err ? RESP : ISSUE;
            end
            ISSUE: begin
                sram_en   = 1'b1;
                state_nxt = (SRAM_LAT == 1) ? CAPTURE : WAIT;
            end
            WAIT: begin
                if (cnt <= 3'd1) state_nxt = CAPTURE;
            end
            CAPTURE: state_nxt = RESP;
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register and the wait-out counter for the macro latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 3'd0;
        end else begin
            state <= state_nxt;
            if (state == ISSUE)
                cnt <= CNT_INIT;
            else if (state == WAIT)
                cnt <= cnt - 3'd1;
        end
    end

    // Latch the winning request; SRAM/shifter controls hold until the next real read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr       <= 1'b0;
            lat_id    <= 1'b0;
            sram_addr <= '0;
            shf_conf  <= 3'b000;
            shf_addr  <= 5'd0;
        end else if (hs) begin
            ptr    <= ~sel_id;
            lat_id <= sel_id;
            if (!sel_err) begin
                sram_addr <= sel_addr[WORD_AW+4:5];
                shf_conf  <= conf_eff;
                shf_addr  <= sel_addr[4:0];
            end
        end
    end

    // Response payload: shifter output on CAPTURE, zero for a rejected request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_data <= 32'd0;
            resp_id   <= 1'b0;
        end else if (hs && sel_err) begin
            resp_data <= 32'd0;
            resp_id   <= sel_id;
        end else if (state == CAPTURE) begin
            resp_data <= shf_dout;
            resp_id   <= lat_id;
        end
    end

`ifdef OSEQ_ALIGN_CHECK_EN
    // Error flag follows the request accepted most recently.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            resp_err <= 1'b0;
        else if (hs)
            resp_err <= sel_err;
    end
`else
    assign resp_err = 1'b0;
`endif

endmodule
